// File: rtl/eq_gain_bank.sv
// Per-band equalizer gain bank: shadow/target/active arrays behind a byte-wide register bus.
// Optional per-sample gain ramping is compiled in when GAIN_RAMP_EN is defined.
module eq_gain_bank #(
  parameter int unsigned N_BANDS    = 10,
  parameter int unsigned GAIN_WIDTH = 13,
  parameter int unsigned RAMP_STEP  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            we_i,
  input  logic                            re_i,
  input  logic [7:0]                      addr_i,
  input  logic [7:0]                      data_in_i,
  output logic [7:0]                      data_out_o,
  input  logic                            sample_tick_i,
  output logic                            busy_o,
  output logic [N_BANDS*GAIN_WIDTH-1:0]   gain_out_o
);

  localparam int unsigned HiW        = GAIN_WIDTH - 8;
  localparam logic [7:0]  CtrlAddr   = 8'hF0;
  localparam logic [7:0]  StatusAddr = 8'hF1;
  localparam logic [8:0]  BandLimit  = 9'(2 * N_BANDS);

  typedef logic [GAIN_WIDTH-1:0] gain_t;

  gain_t shadow_q [N_BANDS];
  gain_t shadow_d [N_BANDS];
  gain_t target_q [N_BANDS];
  gain_t target_d [N_BANDS];
  gain_t active_q [N_BANDS];
  gain_t active_d [N_BANDS];

  logic       addr_err_q, addr_err_d;
  logic [7:0] data_out_q, data_out_d;
  logic       ramp_on_q, ramp_on_d;
  logic       busy;

  logic       is_band, is_ctrl, is_status, unmapped, commit;
  logic [6:0] band_idx;
  logic [7:0] rd_data;

  assign is_band   = {1'b0, addr_i} < BandLimit;
  assign is_ctrl   = addr_i == CtrlAddr;
  assign is_status = addr_i == StatusAddr;
  assign unmapped  = !(is_band || is_ctrl || is_status);
  assign band_idx  = addr_i[7:1];
  assign commit    = we_i && is_ctrl && data_in_i[0];

  // Read mux works on current register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_data = 8'h00;
    if (is_ctrl) begin
      rd_data = {6'b0, ramp_on_q, 1'b0};
    end else if (is_status) begin
      rd_data = {6'b0, addr_err_q, busy};
    end else if (is_band) begin
      for (int b = 0; b < N_BANDS; b++) begin
        if (band_idx == 7'(b)) begin
          rd_data = addr_i[0] ? 8'(shadow_q[b][GAIN_WIDTH-1:8]) : shadow_q[b][7:0];
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      shadow_d[b] = shadow_q[b];
      if (we_i && is_band && band_idx == 7'(b)) begin
        if (addr_i[0]) begin
          shadow_d[b][GAIN_WIDTH-1:8] = data_in_i[HiW-1:0];
        end else begin
          shadow_d[b][7:0] = data_in_i;
        end
      end
    end
  end

  always_comb begin
    addr_err_d = addr_err_q;
    if (we_i && is_status && data_in_i[1]) begin
      addr_err_d = 1'b0;
    end
    if ((we_i || re_i) && unmapped) begin
      addr_err_d = 1'b1;
    end
    data_out_d = re_i ? rd_data : data_out_q;
  end

`ifdef GAIN_RAMP_EN

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e state_q, state_d;
  gain_t  stepped [N_BANDS];
  logic   commit_diff, step_done;

  function automatic gain_t step_toward(gain_t cur, gain_t tgt);
    gain_t diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return (32'(diff) > RAMP_STEP) ? cur + gain_t'(RAMP_STEP) : tgt;
    end else begin
      diff = cur - tgt;
      return (32'(diff) > RAMP_STEP) ? cur - gain_t'(RAMP_STEP) : tgt;
    end
  endfunction

  always_comb begin
    ramp_on_d = ramp_on_q;
    if (we_i && is_ctrl) begin
      ramp_on_d = data_in_i[1];
    end
  end

  always_comb begin
    commit_diff = 1'b0;
    step_done   = 1'b1;
    for (int b = 0; b < N_BANDS; b++) begin
      stepped[b] = step_toward(active_q[b], target_q[b]);
      if (shadow_q[b] != active_q[b]) commit_diff = 1'b1;
      if (stepped[b] != target_q[b])  step_done   = 1'b0;
    end
  end

  // A commit wins over a coincident tick: it only reloads target, stepping resumes next tick.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      target_d[b] = target_q[b];
      active_d[b] = active_q[b];
      if (commit) begin
        target_d[b] = shadow_q[b];
        if (!ramp_on_d) active_d[b] = shadow_q[b];
      end else if (state_q == StRamp && sample_tick_i) begin
        active_d[b] = stepped[b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ramp_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ramp_on_q <= ramp_on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (commit && ramp_on_d && commit_diff) state_d = StRamp;
      end
      StRamp: begin
        if (commit) begin
          state_d = (ramp_on_d && commit_diff) ? StRamp : StIdle;
        end else if (sample_tick_i && step_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = state_q == StRamp;
  end

`else

  logic unused_sample_tick;
  assign unused_sample_tick = sample_tick_i;
  assign ramp_on_q = 1'b0;
  assign ramp_on_d = 1'b0;
  assign busy      = 1'b0;

  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      target_d[b] = commit ? shadow_q[b] : target_q[b];
      active_d[b] = commit ? shadow_q[b] : active_q[b];
    end
  end

`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANDS; b++) begin
        shadow_q[b] <= '0;
        target_q[b] <= '0;
        active_q[b] <= '0;
      end
      addr_err_q <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      for (int b = 0; b < N_BANDS; b++) begin
        shadow_q[b] <= shadow_d[b];
        target_q[b] <= target_d[b];
        active_q[b] <= active_d[b];
      end
      addr_err_q <= addr_err_d;
      data_out_q <= data_out_d;
    end
  end

  for (genvar b = 0; b < N_BANDS; b++) begin : g_gain_out
    assign gain_out_o[b*GAIN_WIDTH +: GAIN_WIDTH] = active_q[b];
  end

  assign data_out_o = data_out_q;
  assign busy_o     = busy;

endmodule

// File: tb/tb_eq_gain_bank.sv
// Directed-vector bench for eq_gain_bank; ramp vectors are used when GAIN_RAMP_EN is defined.
module tb_eq_gain_bank;

  localparam int unsigned NB = 10;
  localparam int unsigned GW = 13;

  logic              clk;
  logic              rst_n;
  logic              we, re, tick;
  logic [7:0]        addr, din, dout;
  logic              busy;
  logic [NB*GW-1:0]  gain;
  logic [7:0]        r;

  int n_vec  = 0;
  int n_miss = 0;

  eq_gain_bank #(
    .N_BANDS   (NB),
    .GAIN_WIDTH(GW),
    .RAMP_STEP (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .we_i         (we),
    .re_i         (re),
    .addr_i       (addr),
    .data_in_i    (din),
    .data_out_o   (dout),
    .sample_tick_i(tick),
    .busy_o       (busy),
    .gain_out_o   (gain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] band(input int b);
    return 32'(gain[b*GW +: GW]);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    re = 1'b1; addr = a;
    cycle();
    re = 1'b0;
    d = dout;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; tick = 1'b0; addr = 8'h00; din = 8'h00;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    check_val("rst_gain", 32'(|gain), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_dout", 32'(dout), 32'h00);
    rd(8'hF0, r); check_val("rst_ctrl", 32'(r), 32'h00);
    rd(8'hF1, r); check_val("rst_status", 32'(r), 32'h00);

    // Shadow writes stay invisible until commit
    wr(8'h00, 8'h00); wr(8'h01, 8'h01);
    check_val("shadow_iso", band(0), 32'h0);
    rd(8'h01, r); check_val("rd_b0_hi", 32'(r), 32'h01);

    wr(8'hF0, 8'h01);
    check_val("commit_b0", band(0), 32'h0100);
    check_val("commit_others", 32'(|(gain >> GW)), 32'h0);
    check_val("commit_busy", 32'(busy), 32'h0);
    rd(8'hF0, r); check_val("commit_rd0", 32'(r), 32'h00);

    wr(8'h03, 8'hFF); rd(8'h03, r); check_val("b1_hi_mask", 32'(r), 32'h1F);
    wr(8'h02, 8'hAB); rd(8'h02, r); check_val("b1_lo", 32'(r), 32'hAB);
    check_val("b1_uncommitted", band(1), 32'h0);

    wr(8'h40, 8'h55);
    rd(8'hF1, r); check_val("err_set", 32'(r), 32'h02);
    check_val("err_nochg", band(0), 32'h0100);
    rd(8'h40, r); check_val("err_rd0", 32'(r), 32'h00);
    wr(8'hF1, 8'h02);
    rd(8'hF1, r); check_val("err_clr", 32'(r), 32'h00);

    // Last mapped band vs first unmapped address
    wr(8'h13, 8'hFF); rd(8'h13, r); check_val("b9_hi", 32'(r), 32'h1F);
    rd(8'hF1, r); check_val("b9_noerr", 32'(r), 32'h00);
    rd(8'h14, r); check_val("addr14_rd", 32'(r), 32'h00);
    rd(8'hF1, r); check_val("addr14_err", 32'(r), 32'h02);
    wr(8'hF1, 8'h02);

    we = 1'b1; re = 1'b1; addr = 8'h04; din = 8'h12;
    cycle();
    we = 1'b0; re = 1'b0;
    check_val("wr_rd_pre", 32'(dout), 32'h00);
    rd(8'h04, r); check_val("wr_rd_post", 32'(r), 32'h12);

    wr(8'hF0, 8'h01);
    check_val("commit_b1", band(1), 32'h1FAB);
    check_val("commit_b9", band(9), 32'h1F00);
    check_val("commit_b2", band(2), 32'h0012);

`ifdef GAIN_RAMP_EN
    wr(8'hF0, 8'h02);
    rd(8'hF0, r); check_val("ramp_on_rd", 32'(r), 32'h02);
    // Restart from band0 = 0 so the up-ramp runs 0 -> 0x100
    wr(8'h01, 8'h00); wr(8'hF0, 8'h01);
    check_val("b0_zero", band(0), 32'h0);
    wr(8'hF0, 8'h02);
    wr(8'h01, 8'h01); wr(8'hF0, 8'h03);
    check_val("ramp_busy", 32'(busy), 32'h1);
    check_val("ramp_start", band(0), 32'h0);
    rd(8'hF1, r); check_val("ramp_status", 32'(r), 32'h01);
    check_val("ramp_no_tick", band(0), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      do_tick();
      check_val("ramp_up", band(0), 32'(16 * k));
      check_val("ramp_up_busy", 32'(busy), (k < 16) ? 32'h1 : 32'h0);
    end

    wr(8'h01, 8'h00); wr(8'hF0, 8'h03);
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      check_val("ramp_dn", band(0), 32'(256 - 16 * k));
    end
    wr(8'h00, 8'h40);
    we = 1'b1; addr = 8'hF0; din = 8'h03; tick = 1'b1;
    cycle();
    we = 1'b0; tick = 1'b0;
    check_val("mid_commit_hold", band(0), 32'h0080);
    check_val("mid_commit_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      check_val("mid_ramp", band(0), 32'(128 - 16 * k));
      check_val("mid_ramp_busy", 32'(busy), (k < 4) ? 32'h1 : 32'h0);
    end

    wr(8'h00, 8'h00); wr(8'hF0, 8'h03);
    do_tick();
    check_val("pre_rst_val", band(0), 32'h0030);
    check_val("pre_rst_busy", 32'(busy), 32'h1);
`else
    wr(8'h00, 8'h34); wr(8'h01, 8'h02); wr(8'hF0, 8'h03);
    check_val("noramp_b0", band(0), 32'h0234);
    check_val("noramp_busy", 32'(busy), 32'h0);
    rd(8'hF0, r); check_val("noramp_ctrl", 32'(r), 32'h00);
    do_tick(); do_tick();
    check_val("noramp_tick", band(0), 32'h0234);
`endif

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_gain", 32'(|gain), 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    #2 rst_n = 1'b1;
    cycle();
    rd(8'hF0, r); check_val("arst_ctrl", 32'(r), 32'h00);
    wr(8'hF0, 8'h01);
    check_val("arst_commit", 32'(|gain), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
